joy_md_pad_reader: RTL and testbench

- Connector-side reader that scans one DB9 port and produces the 6-bit active-low joystick vector consumed by the joystick protocol decoder (db9joy1_in / db9joy2_in format).
- Drives the SELECT pin with a timed sequence and samples the six connector inputs.
- Detects three pad kinds: plain Atari-style stick, Mega Drive 3-button, Mega Drive 6-button.
- Commits one coherent snapshot per scan. One instance per DB9 port.

---
 rtl/joy_md_pad_reader.sv | 158 +++++++++++++++
 tb/tb_joy_md_pad_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/joy_md_pad_reader.sv
// joy_md_pad_reader
//   Scans one DB9 joystick port. Drives SELECT (pin 7) through a timed
//   sequence of phases, samples the six connector inputs at the end of each
//   phase, and classifies the attached pad as one of three kinds:
//   - Atari-style stick
//   - Mega Drive 3-button pad
//   - Mega Drive 6-button pad
//   Once per scan it commits one coherent snapshot to the outputs.
//
//   Optional feature macro: JOY_MD_6BTN_EN
//   - Defined: 8-phase scan, with 6-button detection and X/Y/Z/Mode reporting.
//   - Undefined: 4-phase scan, with 3-button reporting only.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset (internally released synchronously)
//   joy_pins  raw active-low connector inputs {pin9, pin6, up, down, left, right}
//   joy_sel   SELECT drive to connector pin 7
//   joy_out   active-low {fire2, fire1, up, down, left, right}
//   joy_ext   active-low {start, a, x, y, z, mode}
//   pad_type  00 Atari/none, 01 MD 3-button, 10 MD 6-button
//   scan_done one-cycle pulse in the cycle the outputs update
module joy_md_pad_reader #(
  parameter int SEL_DIV  = 224,
  parameter int SCAN_DIV = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] joy_pins,
  output logic       joy_sel,
  output logic [5:0] joy_out,
  output logic [5:0] joy_ext,
  output logic [1:0] pad_type,
  output logic       scan_done
);

  localparam int CNT_MAX = (SCAN_DIV > SEL_DIV) ? SCAN_DIV : SEL_DIV;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SEL_LAST  = CNT_W'(SEL_DIV - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_PH0, ST_PH1, ST_PH2, ST_PH3, ST_PH4, ST_PH5, ST_PH6, ST_PH7
  } state_t;

`ifdef JOY_MD_6BTN_EN
  localparam state_t LAST_PH = ST_PH7;
`else
  localparam state_t LAST_PH = ST_PH3;
`endif

  // Reset asserts asynchronously but releases on a clock edge, so the FSM
  // never leaves reset on a partial cycle.
  logic rst_sync_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_n <= 1'b0;
    else        rst_sync_n <= 1'b1;
  end

  // Stage p0/p1: two-flop synchronizer for the asynchronous connector pins
  logic [5:0] pins_p0, pins_p1;
  always_ff @(posedge clk) begin
    pins_p0 <= joy_pins;
    pins_p1 <= pins_p0;
  end

  // FSM: state register and shared phase/idle counter
  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic            phase_end, idle_end, commit;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end
  end

  // FSM: next-state logic
  always_comb begin
    idle_end  = (state_q == ST_IDLE) && (cnt_q == SCAN_LAST);
    phase_end = (state_q != ST_IDLE) && (cnt_q == SEL_LAST);
    state_d   = state_q;
    if (idle_end)
      state_d = ST_PH0;
    else if (phase_end)
      state_d = (state_q == LAST_PH) ? ST_IDLE : state_t'(state_q + 4'd1);
  end

  // FSM: outputs. SELECT is low in PH0/2/4/6, which are the odd encodings.
  always_comb begin
    joy_sel = (state_q == ST_IDLE) || !state_q[0];
    commit  = phase_end && (state_q == LAST_PH);
  end

  // Shadow registers. They are written only on phase ends and are read only
  // at the commit of a completed scan, so they need no reset.
  logic       md_present_q;
  logic [5:0] ph1_q;
  logic       btn_a_q, btn_start_q;
  logic       six_btn_q;
  logic [3:0] xyzm_q;

  always_ff @(posedge clk) begin
    if (phase_end) begin
      case (state_q)
        ST_PH0: md_present_q <= (pins_p1[1:0] == 2'b00);
        ST_PH1: ph1_q        <= pins_p1;
        ST_PH2: begin
          btn_a_q     <= pins_p1[4];
          btn_start_q <= pins_p1[5];
        end
`ifdef JOY_MD_6BTN_EN
        ST_PH4: six_btn_q <= md_present_q && (pins_p1[3:0] == 4'b0000);
        // Fourth SELECT-high phase: up=Z, down=Y, left=X, right=Mode
        ST_PH5: xyzm_q    <= {pins_p1[1], pins_p1[2], pins_p1[3], pins_p1[0]};
`endif
        default: ;
      endcase
    end
  end

`ifndef JOY_MD_6BTN_EN
  always_comb begin
    six_btn_q = 1'b0;
    xyzm_q    = 4'hF;
  end
`endif

  function automatic logic [5:0] pack_ext(input logic md, input logic six,
                                          input logic st, input logic a,
                                          input logic [3:0] xyzm);
    if (!md)     return 6'h3F;
    else if (six) return {st, a, xyzm};
    else         return {st, a, 4'hF};
  endfunction

  // Commit stage: outputs change only on the last cycle of a full scan
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      joy_out   <= 6'h3F;
      joy_ext   <= 6'h3F;
      pad_type  <= 2'b00;
      scan_done <= 1'b0;
    end else begin
      scan_done <= commit;
      if (commit) begin
        joy_out  <= ph1_q;
        joy_ext  <= pack_ext(md_present_q, six_btn_q, btn_start_q, btn_a_q, xyzm_q);
        pad_type <= !md_present_q ? 2'b00 : (six_btn_q ? 2'b10 : 2'b01);
      end
    end
  end

endmodule

// File: tb/tb_joy_md_pad_reader.sv
module tb_joy_md_pad_reader;

  localparam int S = 64;
  localparam int D = 4;
`ifdef JOY_MD_6BTN_EN
  localparam int NPH = 8;
`else
  localparam int NPH = 4;
`endif
  localparam int PERIOD = S + NPH * D;

  // Button bit positions (1 = pressed)
  localparam int UP = 11, DN = 10, LF = 9, RT = 8, BA = 7, BB = 6, BC = 5;
  localparam int ST = 4, BX = 3, BY = 2, BZ = 1, BM = 0;
  localparam logic [1:0] K_NONE = 0, K_ATARI = 1, K_MD3 = 2, K_MD6 = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] joy_pins = 6'h3F;
  logic       joy_sel, scan_done;
  logic [5:0] joy_out, joy_ext;
  logic [1:0] pad_type;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  joy_md_pad_reader #(.SEL_DIV(D), .SCAN_DIV(S)) dut (
    .clk(clk), .rst_n(rst_n), .joy_pins(joy_pins), .joy_sel(joy_sel),
    .joy_out(joy_out), .joy_ext(joy_ext), .pad_type(pad_type),
    .scan_done(scan_done)
  );

  // Pad behaviour as seen from the connector
  function automatic logic [5:0] pad(input logic [1:0] k, input logic [11:0] b,
                                     input logic sel, input int lows);
    logic [5:0] hi;
    hi = ~{b[BC], b[BB], b[UP], b[DN], b[LF], b[RT]};
    case (k)
      K_ATARI: return hi;
      K_MD3:   return sel ? hi : ~{b[ST], b[BA], b[UP], b[DN], 2'b11};
      K_MD6: begin
        if (sel) return (lows == 3) ? ~{b[BC], b[BB], b[BZ], b[BY], b[BX], b[BM]} : hi;
        if (lows == 3) return ~{b[ST], b[BA], 4'b1111};
        if (lows == 4) return ~{b[ST], b[BA], 4'b0000};
        return ~{b[ST], b[BA], b[UP], b[DN], 2'b11};
      end
      default: return 6'h3F;
    endcase
  endfunction

  logic [1:0]  kind = K_NONE;
  logic [11:0] btn = '0;
  int          lows = 0;
  int          hi_cnt = 0;
  logic        sel_prev = 1'b1;

  // Pad model: a 6-button pad counts SELECT falling edges and forgets them
  // after a long SELECT-high idle.
  always @(negedge clk) begin
    if (joy_sel) begin
      hi_cnt = hi_cnt + 1;
      if (hi_cnt >= 20) lows = 0;
    end else begin
      if (sel_prev) lows = lows + 1;
      hi_cnt = 0;
    end
    sel_prev = joy_sel;
    joy_pins = pad(kind, btn, joy_sel, lows);
  end

  // Expected snapshot, derived from what the pad presents in each phase
  task automatic expect_scan(input logic [1:0] k, input logic [11:0] b,
                             output logic [5:0] eo, output logic [5:0] ee,
                             output logic [1:0] et);
    logic [5:0] s0, s1, s2, s4, s5;
    logic md, six;
    s0 = pad(k, b, 1'b0, 1);
    s1 = pad(k, b, 1'b1, 1);
    s2 = pad(k, b, 1'b0, 2);
    s4 = pad(k, b, 1'b0, 3);
    s5 = pad(k, b, 1'b1, 3);
    md = (s0[1:0] == 2'b00);
`ifdef JOY_MD_6BTN_EN
    six = md && (s4[3:0] == 4'b0000);
`else
    six = 1'b0;
`endif
    eo = s1;
    ee = !md ? 6'h3F : {s2[5], s2[4], six ? {s5[1], s5[2], s5[3], s5[0]} : 4'hF};
    et = !md ? 2'b00 : (six ? 2'b10 : 2'b01);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_done && n < limit);
    chk("scan_done_seen", {7'd0, scan_done}, 8'd1);
  endtask

  task automatic chk_snapshot(input string tag);
    logic [5:0] eo, ee;
    logic [1:0] et;
    expect_scan(kind, btn, eo, ee, et);
    chk({tag, "_out"}, {2'b0, joy_out}, {2'b0, eo});
    chk({tag, "_ext"}, {2'b0, joy_ext}, {2'b0, ee});
    chk({tag, "_type"}, {6'b0, pad_type}, {6'b0, et});
  endtask

  initial begin
    int n;
    logic [1:0] exp_t;
    logic [5:0] exp_e;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sel", {7'd0, joy_sel}, 8'd1);
    chk("rst_out", {2'b0, joy_out}, 8'h3F);
    chk("rst_ext", {2'b0, joy_ext}, 8'h3F);
    chk("rst_type", {6'b0, pad_type}, 8'd0);
    chk("rst_done", {7'd0, scan_done}, 8'd0);

    // Atari stick holding fire1: pins 101111 regardless of SELECT
    kind = K_ATARI;
    btn = 12'b0;
    btn[BB] = 1'b1;
    rst_n = 1'b1;
    wait_done(3 * PERIOD, n);
    chk("atari_out_const", {2'b0, joy_out}, 8'b0010_1111);
    chk_snapshot("atari");
    @(negedge clk);
    chk("done_one_cycle", {7'd0, scan_done}, 8'd0);

    // MD 3-button: B + right
    kind = K_MD3;
    btn = 12'b0;
    btn[BB] = 1'b1;
    btn[RT] = 1'b1;
    wait_done(2 * PERIOD, n);
    chk("md3_out_const", {2'b0, joy_out}, 8'b0010_1110);
    chk("md3_type_const", {6'b0, pad_type}, 8'd1);
    chk_snapshot("md3_b_right");

    // MD 3-button: Start
    btn = 12'b0;
    btn[ST] = 1'b1;
    wait_done(2 * PERIOD, n);
    chk("md3_period", n[7:0], PERIOD[7:0]);
    chk("md3_start_ext", {2'b0, joy_ext}, 8'b0001_1111);
    chk_snapshot("md3_start");

    // MD 6-button: X
    kind = K_MD6;
    btn = 12'b0;
    btn[BX] = 1'b1;
    wait_done(2 * PERIOD, n);
`ifdef JOY_MD_6BTN_EN
    exp_t = 2'b10;
    exp_e = 6'b110111;
`else
    exp_t = 2'b01;
    exp_e = 6'h3F;
`endif
    chk("md6_x_type", {6'b0, pad_type}, {6'b0, exp_t});
    chk("md6_x_ext", {2'b0, joy_ext}, {2'b0, exp_e});
    chk_snapshot("md6_x");

    // Randomized pads and buttons
    for (int i = 0; i < 16; i++) begin
      kind = 2'($urandom_range(0, 3));
      btn = 12'($urandom);
      wait_done(2 * PERIOD, n);
      chk("rand_period", n[7:0], PERIOD[7:0]);
      chk_snapshot("rand");
    end

    // Hot-unplug after a 6-button pad
    kind = K_MD6;
    btn = 12'b0;
    btn[BZ] = 1'b1;
    btn[UP] = 1'b1;
    wait_done(2 * PERIOD, n);
    chk_snapshot("md6_before_unplug");
    kind = K_NONE;
    wait_done(2 * PERIOD, n);
    chk("unplug_type", {6'b0, pad_type}, 8'd0);
    chk("unplug_out", {2'b0, joy_out}, 8'h3F);
    chk("unplug_ext", {2'b0, joy_ext}, 8'h3F);

    // Reset in the middle of a scan (PH2, SELECT low) with buttons held
    kind = K_MD6;
    btn = 12'b0;
    btn[BB] = 1'b1;
    btn[LF] = 1'b1;
    btn[ST] = 1'b1;
    wait_done(2 * PERIOD, n);
    chk_snapshot("md6_before_reset");
    repeat (S + 2 * D + 1) @(negedge clk);
    chk("ph2_sel_low", {7'd0, joy_sel}, 8'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_sel", {7'd0, joy_sel}, 8'd1);
    chk("midrst_out", {2'b0, joy_out}, 8'h3F);
    chk("midrst_ext", {2'b0, joy_ext}, 8'h3F);
    chk("midrst_type", {6'b0, pad_type}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done(2 * PERIOD, n);
    chk("post_rst_latency", n[7:0], 8'(PERIOD + 1));
    chk_snapshot("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
